// File: rtl/vend_ctrl_gen.sv
// Vending controller: keypad slot selection, saturating coin credit, programmable price table,
// cancel/refund and keypad timeout. Optional per-slot stock counting when VEND_STOCK_EN is defined.
module vend_ctrl_gen #(
    parameter int ROWS          = 4,
    parameter int COLS          = 4,
    parameter int VAL_W         = 16,
    parameter int DEFAULT_PRICE = 100,
    parameter int TIMEOUT_CYC   = 1000
`ifdef VEND_STOCK_EN
    ,
    parameter int STOCK_W       = 4,
    parameter int STOCK_INIT    = 10
`endif
) (
    input  logic                                 I_CLK,
    input  logic                                 I_RESET,
    input  logic [ROWS-1:0]                      I_ROW_KEY,
    input  logic [COLS-1:0]                      I_COL_KEY,
    input  logic                                 I_COIN_VLD,
    input  logic [VAL_W-1:0]                     I_COIN_VAL,
    input  logic                                 I_CANCEL,
    input  logic                                 I_PRICE_WE,
    input  logic [$clog2(ROWS)+$clog2(COLS)-1:0] I_PRICE_ADDR,
    input  logic [VAL_W-1:0]                     I_PRICE_DATA,
    output logic [$clog2(ROWS)+$clog2(COLS)-1:0] O_SEL,
    output logic [VAL_W-1:0]                     O_PRICE,
    output logic [VAL_W-1:0]                     O_CREDIT,
    output logic [VAL_W-1:0]                     O_CHANGE,
    output logic                                 O_CHANGE_VLD,
    output logic                                 O_SUCCESS,
    output logic                                 O_DENY,
`ifdef VEND_STOCK_EN
    output logic                                 O_SOLD_OUT,
`endif
    output logic                                 O_BUSY
);
    localparam int ROW_W = $clog2(ROWS);
    localparam int COL_W = $clog2(COLS);
    localparam int SEL_W = ROW_W + COL_W;
    localparam int NSLOT = ROWS * COLS;
    localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [2:0] {S_IDLE, S_ROW, S_CHECK, S_VEND, S_REFUND} state_t;

    state_t             state;
    logic [VAL_W-1:0]   credit;
    logic [ROW_W-1:0]   row;
    logic [SEL_W-1:0]   sel;
    logic [TMR_W-1:0]   timer;
    logic [VAL_W-1:0]   price [NSLOT];
`ifdef VEND_STOCK_EN
    logic [STOCK_W-1:0] stock [NSLOT];
`endif

    logic               row_ok, col_ok, cancel_ok;
    logic [ROW_W-1:0]   row_idx;
    logic [COL_W-1:0]   col_idx;
    logic [VAL_W-1:0]   coin_add, credit_acc, price_sel;
    logic [VAL_W:0]     credit_sum;

    assign row_ok     = $onehot(I_ROW_KEY);
    assign col_ok     = $onehot(I_COL_KEY);
    assign cancel_ok  = I_CANCEL && (state == S_IDLE || state == S_ROW || state == S_CHECK);
    assign coin_add   = I_COIN_VLD ? I_COIN_VAL : '0;
    assign credit_sum = {1'b0, credit} + {1'b0, coin_add};
    assign credit_acc = credit_sum[VAL_W] ? '1 : credit_sum[VAL_W-1:0];
    assign price_sel  = price[sel];
    assign O_CREDIT   = credit;

    always_comb begin
        row_idx = '0;
        for (int i = 0; i < ROWS; i++)
            if (I_ROW_KEY[i]) row_idx = ROW_W'(i);
        col_idx = '0;
        for (int j = 0; j < COLS; j++)
            if (I_COL_KEY[j]) col_idx = COL_W'(j);
    end

    // Write at the edge means a same-cycle check still reads the old entry.
    always_ff @(posedge I_CLK) begin
        if (I_RESET) begin
            for (int k = 0; k < NSLOT; k++) price[k] <= VAL_W'(DEFAULT_PRICE);
        end else if (I_PRICE_WE) begin
            price[I_PRICE_ADDR] <= I_PRICE_DATA;
        end
    end

    always_ff @(posedge I_CLK) begin
        if (I_RESET) begin
            state        <= S_IDLE;
            credit       <= '0;
            row          <= '0;
            sel          <= '0;
            timer        <= '0;
            O_SEL        <= '0;
            O_PRICE      <= '0;
            O_CHANGE     <= '0;
            O_CHANGE_VLD <= 1'b0;
            O_SUCCESS    <= 1'b0;
            O_DENY       <= 1'b0;
            O_BUSY       <= 1'b0;
`ifdef VEND_STOCK_EN
            O_SOLD_OUT   <= 1'b0;
            for (int k = 0; k < NSLOT; k++) stock[k] <= STOCK_W'(STOCK_INIT);
`endif
        end else begin
            O_CHANGE_VLD <= 1'b0;
            O_SUCCESS    <= 1'b0;
            O_DENY       <= 1'b0;
            O_BUSY       <= 1'b0;
`ifdef VEND_STOCK_EN
            O_SOLD_OUT   <= 1'b0;
`endif
            credit       <= credit_acc;
            if (state == S_CHECK) O_PRICE <= price_sel;

            // Pulses are registered on entry so they are high during the VEND/REFUND cycle.
            if (cancel_ok) begin
                state  <= S_REFUND;
                timer  <= '0;
                O_BUSY <= 1'b1;
                if (credit_acc != '0) begin
                    O_CHANGE     <= credit_acc;
                    O_CHANGE_VLD <= 1'b1;
                end
            end else begin
                case (state)
                    S_IDLE: begin
                        if (row_ok) begin
                            row   <= row_idx;
                            timer <= '0;
                            state <= S_ROW;
                        end
                    end
                    S_ROW: begin
                        if (col_ok) begin
                            sel    <= {row, col_idx};
                            timer  <= '0;
                            state  <= S_CHECK;
                            O_BUSY <= 1'b1;
                        end else if (row_ok) begin
                            row   <= row_idx;
                            timer <= '0;
                        end else if (!I_COIN_VLD) begin
                            if (timer == TMR_W'(TIMEOUT_CYC - 1)) begin
                                timer <= '0;
                                state <= S_IDLE;
                            end else begin
                                timer <= timer + 1'b1;
                            end
                        end
                    end
                    S_CHECK: begin
`ifdef VEND_STOCK_EN
                        if (stock[sel] == '0) begin
                            O_DENY     <= 1'b1;
                            O_SOLD_OUT <= 1'b1;
                            state      <= S_IDLE;
                        end else
`endif
                        if (credit >= price_sel) begin
                            O_SUCCESS    <= 1'b1;
                            O_SEL        <= sel;
                            O_CHANGE     <= credit_acc - price_sel;
                            O_CHANGE_VLD <= 1'b1;
                            O_BUSY       <= 1'b1;
                            state        <= S_VEND;
                        end else begin
                            O_DENY <= 1'b1;
                            state  <= S_IDLE;
                        end
                    end
                    S_VEND: begin
                        credit <= coin_add;
`ifdef VEND_STOCK_EN
                        if (stock[sel] != '0) stock[sel] <= stock[sel] - 1'b1;
`endif
                        state  <= S_IDLE;
                    end
                    S_REFUND: begin
                        credit <= coin_add;
                        state  <= S_IDLE;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_vend_ctrl_gen.sv
// Directed bench for vend_ctrl_gen: a 16-bit instance with short timeout and an 8-bit instance
// for saturation; the stock scenario runs on the 8-bit instance when VEND_STOCK_EN is defined.
module tb_vend_ctrl_gen;
    localparam int TMO = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // 16-bit instance
    logic [3:0]  a_row_key = '0, a_col_key = '0;
    logic        a_coin_vld = 1'b0, a_cancel = 1'b0, a_we = 1'b0;
    logic [15:0] a_coin_val = '0, a_pdata = '0;
    logic [3:0]  a_paddr = '0;
    logic [3:0]  a_sel;
    logic [15:0] a_price, a_credit, a_change;
    logic        a_chg_vld, a_success, a_deny, a_busy;

    // 8-bit instance
    logic [3:0]  b_row_key = '0, b_col_key = '0;
    logic        b_coin_vld = 1'b0, b_cancel = 1'b0;
    logic [7:0]  b_coin_val = '0;
    logic [3:0]  b_sel;
    logic [7:0]  b_price, b_credit, b_change;
    logic        b_chg_vld, b_success, b_deny, b_busy;
`ifdef VEND_STOCK_EN
    logic        a_sold_out, b_sold_out;
`endif

    vend_ctrl_gen #(.VAL_W(16), .TIMEOUT_CYC(TMO)) u_a (
        .I_CLK(clk), .I_RESET(rst), .I_ROW_KEY(a_row_key), .I_COL_KEY(a_col_key),
        .I_COIN_VLD(a_coin_vld), .I_COIN_VAL(a_coin_val), .I_CANCEL(a_cancel),
        .I_PRICE_WE(a_we), .I_PRICE_ADDR(a_paddr), .I_PRICE_DATA(a_pdata),
        .O_SEL(a_sel), .O_PRICE(a_price), .O_CREDIT(a_credit), .O_CHANGE(a_change),
        .O_CHANGE_VLD(a_chg_vld), .O_SUCCESS(a_success), .O_DENY(a_deny),
`ifdef VEND_STOCK_EN
        .O_SOLD_OUT(a_sold_out),
`endif
        .O_BUSY(a_busy)
    );

    vend_ctrl_gen #(
        .VAL_W(8), .TIMEOUT_CYC(TMO)
`ifdef VEND_STOCK_EN
        , .STOCK_INIT(1)
`endif
    ) u_b (
        .I_CLK(clk), .I_RESET(rst), .I_ROW_KEY(b_row_key), .I_COL_KEY(b_col_key),
        .I_COIN_VLD(b_coin_vld), .I_COIN_VAL(b_coin_val), .I_CANCEL(b_cancel),
        .I_PRICE_WE(1'b0), .I_PRICE_ADDR(4'd0), .I_PRICE_DATA(8'd0),
        .O_SEL(b_sel), .O_PRICE(b_price), .O_CREDIT(b_credit), .O_CHANGE(b_change),
        .O_CHANGE_VLD(b_chg_vld), .O_SUCCESS(b_success), .O_DENY(b_deny),
`ifdef VEND_STOCK_EN
        .O_SOLD_OUT(b_sold_out),
`endif
        .O_BUSY(b_busy)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic a_coin(input int v);
        a_coin_vld = 1'b1; a_coin_val = 16'(v); cyc(); a_coin_vld = 1'b0;
    endtask
    task automatic a_row(input logic [3:0] k);
        a_row_key = k; cyc(); a_row_key = '0;
    endtask
    task automatic a_col(input logic [3:0] k);
        a_col_key = k; cyc(); a_col_key = '0;
    endtask
    task automatic b_coin(input int v);
        b_coin_vld = 1'b1; b_coin_val = 8'(v); cyc(); b_coin_vld = 1'b0;
    endtask

    initial begin
        cyc(2);
        rst = 1'b0;
        chk("rst_credit", a_credit, 0);
        chk("rst_busy", a_busy, 0);
        chk("rst_success", a_success, 0);
        chk("rst_chg_vld", a_chg_vld, 0);
        chk("rst_sel", a_sel, 0);

        // A1 at default price, exact credit
        a_coin(100);
        chk("s1_credit", a_credit, 100);
        a_row(4'b0001); a_col(4'b0001);
        chk("s1_busy_check", a_busy, 1);
        cyc();
        chk("s1_success", a_success, 1);
        chk("s1_sel", a_sel, 0);
        chk("s1_change", a_change, 0);
        chk("s1_chg_vld", a_chg_vld, 1);
        cyc();
        chk("s1_credit_after", a_credit, 0);
        chk("s1_success_pulse", a_success, 0);

        // price[5]=250, deny then vend with change
        a_we = 1'b1; a_paddr = 4'd5; a_pdata = 16'd250; cyc(); a_we = 1'b0;
        a_coin(100); a_coin(100);
        a_row(4'b0010); a_col(4'b0010);
        cyc();
        chk("s2_deny", a_deny, 1);
        chk("s2_no_success", a_success, 0);
        chk("s2_price", a_price, 250);
        chk("s2_credit_kept", a_credit, 200);
        a_coin(100);
        a_row(4'b0010); a_col(4'b0010);
        cyc();
        chk("s2_success", a_success, 1);
        chk("s2_change", a_change, 50);
        chk("s2_sel", a_sel, 5);
        cyc();

        // price write in the check cycle does not affect that check
        a_coin(100);
        a_row(4'b0001); a_col(4'b0001);
        a_we = 1'b1; a_paddr = 4'd0; a_pdata = 16'd200; cyc(); a_we = 1'b0;
        chk("pw_success", a_success, 1);
        chk("pw_change", a_change, 0);
        cyc();
        a_coin(150);
        a_row(4'b0001); a_col(4'b0001); cyc();
        chk("pw_deny_new", a_deny, 1);
        chk("pw_price_new", a_price, 200);
        a_cancel = 1'b1; cyc(); a_cancel = 1'b0;
        chk("pw_refund", a_change, 150);
        cyc();

        // last letter wins
        a_coin(100); a_coin(100); a_coin(100); a_coin(100);
        a_row(4'b0001); a_row(4'b0010); a_row(4'b1000); a_col(4'b1000);
        cyc();
        chk("s3_success", a_success, 1);
        chk("s3_sel", a_sel, 15);
        chk("s3_change", a_change, 300);
        cyc();

        // multi-hot row key ignored, so the column key finds the FSM idle
        a_coin(50);
        a_row(4'b0011); a_col(4'b0001); cyc();
        chk("inv_no_deny", a_deny, 0);
        chk("inv_no_busy", a_busy, 0);

        // timeout boundary: TMO-1 idle cycles still in row state, TMO cycles back to idle
        a_row(4'b0100); cyc(TMO - 1); a_col(4'b0001); cyc();
        chk("tmo_edge_deny", a_deny, 1);
        chk("tmo_credit", a_credit, 50);
        a_row(4'b0100); cyc(TMO); a_col(4'b0001); cyc();
        chk("tmo_expired_no_deny", a_deny, 0);
        a_cancel = 1'b1; cyc(); a_cancel = 1'b0;
        chk("tmo_refund_vld", a_chg_vld, 1);
        chk("tmo_refund", a_change, 50);
        chk("tmo_refund_busy", a_busy, 1);
        cyc();
        chk("tmo_credit_zero", a_credit, 0);

        // cancel with no credit: no refund pulse
        a_cancel = 1'b1; cyc(); a_cancel = 1'b0;
        chk("zero_refund_vld", a_chg_vld, 0);
        chk("zero_refund_busy", a_busy, 1);
        cyc();

        // reset during check discards credit, no vend
        a_coin(100);
        a_row(4'b0001); a_col(4'b0001);
        rst = 1'b1; cyc(); rst = 1'b0;
        chk("rstmid_success", a_success, 0);
        chk("rstmid_credit", a_credit, 0);
        chk("rstmid_busy", a_busy, 0);
        cyc();
        chk("rstmid_no_late_success", a_success, 0);

        // 8-bit saturation and cancel beating a column key
        b_coin(200); b_coin(100);
        chk("sat_credit", b_credit, 255);
        b_row_key = 4'b0001; cyc(); b_row_key = '0;
        b_cancel = 1'b1; b_col_key = 4'b0001; cyc(); b_cancel = 1'b0; b_col_key = '0;
        chk("sat_refund_vld", b_chg_vld, 1);
        chk("sat_refund", b_change, 255);
        chk("sat_no_success", b_success, 0);
        cyc();
        chk("sat_no_late_success", b_success, 0);
        chk("sat_no_deny", b_deny, 0);
        chk("sat_credit_zero", b_credit, 0);

`ifdef VEND_STOCK_EN
        b_coin(100);
        b_row_key = 4'b0001; cyc(); b_row_key = '0;
        b_col_key = 4'b0001; cyc(); b_col_key = '0;
        cyc();
        chk("stk_first_success", b_success, 1);
        chk("stk_first_sold_out", b_sold_out, 0);
        cyc();
        b_coin(100);
        b_row_key = 4'b0001; cyc(); b_row_key = '0;
        b_col_key = 4'b0001; cyc(); b_col_key = '0;
        cyc();
        chk("stk_second_success", b_success, 0);
        chk("stk_second_deny", b_deny, 1);
        chk("stk_second_sold_out", b_sold_out, 1);
        chk("stk_credit_kept", b_credit, 100);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/vend_ctrl_gen.md
Name: vend_ctrl_gen

Overview:
Clocked, parametrised vending controller.
- Keypad: ROWS letter keys × COLS digit keys.
- Coin-accumulating credit register, runtime-programmable price table, cancel/refund path, keypad inactivity timeout.
- Sits between keypad/coin-acceptor front end and dispenser/change-hopper back end; back end consumes one-cycle O_SUCCESS / O_CHANGE_VLD pulses.

Parameters:
ROWS, 4, number of letter keys (power of 2, ≥2)
COLS, 4, number of digit keys (power of 2, ≥2)
VAL_W, 16, width of coin, credit, price, change values (cents)
DEFAULT_PRICE, 100, reset value of every price-table entry
TIMEOUT_CYC, 1000, idle cycles in S_ROW before abandoning a letter press
Derived localparams: ROW_W=clog2(ROWS), COL_W=clog2(COLS), SEL_W=ROW_W+COL_W

Ports:
I_CLK  in  1  clock, all logic rising-edge
I_RESET  in  1  synchronous, active-high
I_ROW_KEY  in  ROWS  letter keys, one-hot single-cycle pulse
I_COL_KEY  in  COLS  digit keys, one-hot single-cycle pulse
I_COIN_VLD  in  1  coin accepted this cycle
I_COIN_VAL  in  VAL_W  coin value, qualified by I_COIN_VLD
I_CANCEL  in  1  refund request pulse
I_PRICE_WE  in  1  price-table write strobe
I_PRICE_ADDR  in  SEL_W  price-table index
I_PRICE_DATA  in  VAL_W  new price
O_SEL  out  SEL_W  last vended slot, row*COLS+col
O_PRICE  out  VAL_W  price of last checked slot
O_CREDIT  out  VAL_W  current credit
O_CHANGE  out  VAL_W  change/refund amount, valid with O_CHANGE_VLD
O_CHANGE_VLD  out  1  one-cycle pulse
O_SUCCESS  out  1  one-cycle vend pulse
O_DENY  out  1  one-cycle pulse: insufficient credit
O_BUSY  out  1  high in S_CHECK, S_VEND, S_REFUND

Behaviour:
- Reset (I_RESET high at clock edge): state S_IDLE; all outputs 0; credit 0; row latch 0; timeout counter 0; every price entry = DEFAULT_PRICE. Reset wins over every other input, including mid-vend. Credit is discarded, no refund pulse.
- Key validity: a key vector that is not one-hot (zero or multi-hot) is ignored.
- States:
  - S_IDLE: valid row key → latch row, go S_ROW. Column key ignored.
  - S_ROW: valid row key → overwrite latch (last letter wins), clear timer. Valid column key → sel = row*COLS+col, go S_CHECK. Timer increments each cycle with no key and no coin; at TIMEOUT_CYC-1 → S_IDLE, credit kept.
  - S_CHECK (exactly 1 cycle): O_PRICE ← price[sel]. If credit ≥ price → S_VEND. Else pulse O_DENY next cycle, → S_IDLE, credit kept.
  - S_VEND: O_SUCCESS=1, O_SEL=sel, O_CHANGE=credit−price, O_CHANGE_VLD=1 (also when change is 0), credit ← 0, → S_IDLE.
  - S_REFUND: O_CHANGE=credit, O_CHANGE_VLD=1, credit ← 0, → S_IDLE. Pulse is suppressed if credit is 0.
- Latency: column key at edge N → S_CHECK at N+1 → O_SUCCESS or O_DENY high during cycle N+2.
- Credit: I_COIN_VLD adds I_COIN_VAL in any state and saturates at 2^VAL_W−1. A coin arriving in the S_VEND/S_REFUND cycle becomes the new credit; it is not paid out.
- Cancel: honoured in S_IDLE, S_ROW, S_CHECK → S_REFUND. Cancel beats a simultaneous key or vend decision. Ignored in S_VEND/S_REFUND.
- Price writes: accepted in any state, visible from the next cycle. A write in the S_CHECK cycle does not affect that check.
- O_SEL and O_PRICE hold their values until the next update.

Optional Feature:
VEND_STOCK_EN
- Defined:
  - Adds parameters STOCK_W (default 4) and STOCK_INIT (default 10), and output O_SOLD_OUT (1).
  - Per-slot stock counter, reset to STOCK_INIT, decremented in S_VEND.
  - In S_CHECK, stock 0 → O_DENY and O_SOLD_OUT pulse together; credit kept; counter never wraps below 0.
- Undefined: no counters and no O_SOLD_OUT port; stock is unlimited.

Test Plan:
- Reset; coin 100; keys A then 1 → O_SUCCESS pulse, O_SEL=0, O_CHANGE=0 with O_CHANGE_VLD, O_CREDIT=0.
- Write price[5]=250; coins 100+100; keys B,2 → O_DENY, O_PRICE=250, O_CREDIT=200; add coin 100; B,2 → O_SUCCESS, O_CHANGE=50.
- Coins 4×100; keys A,B,D,4 → O_SEL=15, O_CHANGE=300 (default price 100).
- Coins 25+25; key C, then no input for TIMEOUT_CYC cycles → S_IDLE; I_CANCEL → O_CHANGE=50, O_CHANGE_VLD pulse.
- VAL_W=8: coins 200+100 → O_CREDIT=255; same-cycle I_CANCEL and column key → refund 255, no vend.
- VEND_STOCK_EN, STOCK_INIT=1: two vends of slot 0 with credit 100 each → first O_SUCCESS; second O_DENY+O_SOLD_OUT, O_CREDIT=100.
